bit_serializer: RTL

- Parallel-to-serial front end that feeds the single-bit `x` input of the downstream sequence detector (1011 detector).
- Accepts W-bit words over a valid/ready handshake and shifts each word out one bit per clock, with a bit-valid qualifier.
- Streams back-to-back words with zero bubble cycles.
- A `hold` input stalls shifting.

---
 rtl/serial_pkg.sv | 13 +
 rtl/ser_bit_counter.sv | 32 +++
 rtl/bit_serializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit serializer and the detector test environment.
package serial_pkg;

   // Serializer FSM encoding
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_e;

   // Default word width, shared with the 1011 detector environment
   localparam int SER_W = 4;

endpackage : serial_pkg

// File: rtl/ser_bit_counter.sv
// Modulo-W bit counter: load clears to 0, enable increments, tc flags W-1.
module ser_bit_counter
   import serial_pkg::*;
#(
   parameter int W  = SER_W,
   parameter int CW = $clog2(W)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   // Count register; load has priority so the count only wraps via reload
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Terminal count: final bit of the word
   always_comb begin
      tc = (cnt == CW'(W - 1));
   end

endmodule : ser_bit_counter

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the 1011 sequence detector.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no word loaded; din_ready=1, x_out=IDLE_VAL, x_valid=0
// ST_SHIFT | word in shreg; one bit per unstalled clock, reload on last bit
module bit_serializer
   import serial_pkg::*;
#(
   parameter int   W         = SER_W,
   parameter bit   LSB_FIRST = 1'b0,
   parameter logic IDLE_VAL  = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         hold,
   output logic         x_out,
   output logic         x_valid,
   output logic         last,
   output logic         busy
);

   localparam int CW = $clog2(W);

   ser_state_e    state;
   logic [W-1:0]  shreg;
   logic [CW-1:0] bit_cnt;
   logic          cnt_tc;
   logic          in_shift;
   logic          advance;
   logic          word_end;
   logic          xfer;
   logic          cnt_load;

   // Handshake and advance qualifiers; ready never looks at din_valid
   always_comb begin
      in_shift  = (state == ST_SHIFT);
      advance   = in_shift & ~hold;
      word_end  = advance & cnt_tc;
      din_ready = ~in_shift | word_end;
      xfer      = din_valid & din_ready;
      // Clearing on a word end without a new word keeps bit_cnt at 0 in IDLE
      cnt_load  = xfer | word_end;
   end

   ser_bit_counter #(
      .W  (W),
      .CW (CW)
   ) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .en    (advance),
      .cnt   (bit_cnt),
      .tc    (cnt_tc)
   );

   // FSM and shift register; din is captured only on a transfer edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         shreg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  shreg <= din;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (advance) begin
                  if (xfer) begin
                     shreg <= din;
                  end else begin
                     shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                     if (cnt_tc) begin
                        state <= ST_IDLE;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Serial outputs follow the current word; hold only gates the qualifiers
   always_comb begin
      busy    = in_shift;
      x_valid = advance;
      last    = advance & cnt_tc;
      if (in_shift) begin
         x_out = LSB_FIRST ? shreg[0] : shreg[W-1];
      end else begin
         x_out = IDLE_VAL;
      end
   end

endmodule : bit_serializer
